// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU command sequencer and its timer:
//   operation encodings presented on the ALU select lines, the
//   sequencer FSM state encoding and the default datapath width.
//   No ports (package).
package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 8;

  // Select encoding understood by the external combinational ALU.
  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'b00,
    ALU_OP_SUB = 2'b01,
    ALU_OP_AND = 2'b10,
    ALU_OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_RESP  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer
//   Loadable 4-bit down-counter used to hold the ALU operands for the
//   settle time before the result is captured. Counting stops at zero.
// Ports
//   clk         in   clock, rising edge
//   srst        in   synchronous active-high reset (count -> 0)
//   load        in   load load_value (has priority over dec)
//   load_value  in   4-bit start value
//   dec         in   decrement when non-zero
//   zero        out  count == 0
module alu_seq_timer (
  input  logic       clk,
  input  logic       srst,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= 4'd0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != 4'd0)) begin
      count_reg <= count_reg - 4'd1;
    end
  end

  assign zero = (count_reg == 4'd0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Initiator for an external combinational 4-op ALU. A command accepted
//   over cmd_valid/cmd_ready is registered onto alu_a/alu_b/alu_sel, held
//   for SETTLE_CYCLES cycles, then the ALU result, carry and a zero flag
//   are captured and returned over rsp_valid/rsp_ready. One operation is
//   in flight at a time; op_count counts completed responses and wraps.
// Optional feature (macro ALU_SEQ_CHAIN_EN)
//   Adds input cmd_chain: when a command is accepted with cmd_chain=1,
//   operand A is the last captured rsp_data instead of cmd_a.
// Ports
//   wb_clk_i, wb_rst_i              clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_a, cmd_b            operation (00 add,01 sub,10 and,11 or)
//   alu_a, alu_b, alu_sel           registered operands/select to the ALU
//   alu_out, alu_carry              ALU result and carry/borrow
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_carry, rsp_zero   captured result, carry, result==0
//   op_count                        completed responses (wraps)
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH_DEFAULT,
  parameter int SETTLE_CYCLES = 1,   // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic             cmd_chain,
`endif
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e       state_reg;
  logic             cmd_ready_reg;
  logic             rsp_valid_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  alu_op_e          alu_sel_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_carry_reg;
  logic             rsp_zero_reg;
  logic [CNT_W-1:0] op_count_reg;

  logic             accept;
  logic             timer_zero;
  logic [WIDTH-1:0] operand_a;

  // cmd_ready is a register, so accept never depends combinationally
  // on cmd_valid through cmd_ready.
  assign accept = (state_reg == ST_IDLE) && cmd_ready_reg && cmd_valid;

`ifdef ALU_SEQ_CHAIN_EN
  // rsp_data_reg doubles as the chaining register: it is 0 after reset
  // and updates only at capture.
  assign operand_a = cmd_chain ? rsp_data_reg : cmd_a;
`else
  assign operand_a = cmd_a;
`endif

  alu_seq_timer u_timer (
    .clk        (wb_clk_i),
    .srst       (wb_rst_i),
    .load       (accept),
    .load_value (SETTLE_LOAD),
    .dec        (state_reg == ST_DRIVE),
    .zero       (timer_zero)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_sel_reg   <= ALU_OP_ADD;
      rsp_data_reg  <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cmd_ready_reg <= 1'b1;
          if (accept) begin
            alu_a_reg     <= operand_a;
            alu_b_reg     <= cmd_b;
            alu_sel_reg   <= alu_op_e'(cmd_op);
            cmd_ready_reg <= 1'b0;
            state_reg     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (timer_zero) begin
            rsp_data_reg  <= alu_out;
            rsp_carry_reg <= alu_carry;
            rsp_zero_reg  <= (alu_out == '0);
            rsp_valid_reg <= 1'b1;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + 1'b1;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          cmd_ready_reg <= 1'b0;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign rsp_valid = rsp_valid_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Bench for alu_cmd_sequencer with a behavioural ALU attached. A small
//   op counter width is used so the wrap of op_count is exercised.
//   Expected responses are queued when a command is issued and popped
//   when the response appears. Optional chain tests under ALU_SEQ_CHAIN_EN.
module tb_alu_cmd_sequencer;

  localparam int WIDTH         = 8;
  localparam int SETTLE_CYCLES = 1;
  localparam int CNT_W         = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             zero;
  } exp_t;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic             cmd_chain = 1'b0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic [CNT_W-1:0] op_count;

  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_count = '0;
  exp_t             sb_q[$];

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural 4-op ALU: 9-bit result, bit 8 is carry/borrow.
  logic [WIDTH:0] alu_full;
  always_comb begin
    alu_full = '0;
    case (alu_sel)
      2'b00:   alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_full = {1'b0, alu_a} - {1'b0, alu_b};
      2'b10:   alu_full = {1'b0, alu_a & alu_b};
      default: alu_full = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_out   = alu_full[WIDTH-1:0];
  assign alu_carry = alu_full[WIDTH];

  alu_cmd_sequencer #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain (cmd_chain),
`endif
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero),
    .op_count  (op_count)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result computed with integer arithmetic.
  function automatic exp_t ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t r;
    int   s;
    r = '0;
    case (op)
      2'b00: begin s = int'(a) + int'(b); r.data = s[7:0]; r.carry = (s > 255); end
      2'b01: begin s = int'(a) - int'(b); r.data = s[7:0]; r.carry = (a < b); end
      2'b10: r.data = a & b;
      default: r.data = a | b;
    endcase
    r.zero = (r.data == 8'h00);
    return r;
  endfunction

  // Issue one command from a negedge, follow it to its response and
  // handshake it. stall<0: rsp_ready high early; else held low stall cycles.
  task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic chain, input logic [7:0] a_exp, input exp_t exp, input int stall);
    int   n;
    exp_t e;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge wb_clk_i); n++; end
    check_val("cmd_ready_idle", cmd_ready, 1);
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
    rsp_ready = (stall < 0);
    sb_q.push_back(exp);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0; cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 2'($urandom);
    check_val("drive_cmd_ready", cmd_ready, 0);
    check_val("drive_alu_sel", alu_sel, op);
    check_val("drive_alu_a", alu_a, a_exp);
    check_val("drive_alu_b", alu_b, b);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge wb_clk_i); n++; end
    check_val("latency", n, SETTLE_CYCLES);
    e = sb_q.pop_front();
    if (!rsp_valid) begin rsp_ready = 1'b0; return; end
    for (int i = 0; i < stall; i++) begin
      @(negedge wb_clk_i);
      check_val("stall_rsp_valid", rsp_valid, 1);
      check_val("stall_rsp_data", rsp_data, e.data);
      check_val("stall_cmd_ready", cmd_ready, 0);
      check_val("stall_op_count", op_count, exp_count);
    end
    check_val("rsp_data", rsp_data, e.data);
    check_val("rsp_carry", rsp_carry, e.carry);
    check_val("rsp_zero", rsp_zero, e.zero);
    rsp_ready = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check_val("op_count", op_count, exp_count);
    check_val("rsp_valid_drop", rsp_valid, 0);
    $display("op=%0d a=%02h b=%02h -> data=%02h carry=%0b zero=%0b count=%0d",
             op, a_exp, b, e.data, e.carry, e.zero, exp_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_alu_a"}, alu_a, 0);
    check_val({tag, "_alu_b"}, alu_b, 0);
    check_val({tag, "_alu_sel"}, alu_sel, 0);
    check_val({tag, "_rsp_data"}, rsp_data, 0);
    check_val({tag, "_rsp_carry"}, rsp_carry, 0);
    check_val({tag, "_rsp_zero"}, rsp_zero, 0);
    check_val({tag, "_op_count"}, op_count, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    exp_t       exp;
    int         stall;
  } vec_t;

  vec_t dir_tbl[6] = '{
    '{2'b00, 8'hF0, 8'h20, '{8'h10, 1'b1, 1'b0}, 0},
    '{2'b01, 8'h05, 8'h07, '{8'hFE, 1'b1, 1'b0}, -1},
    '{2'b01, 8'h07, 8'h07, '{8'h00, 1'b0, 1'b1}, 1},
    '{2'b10, 8'hCC, 8'hAA, '{8'h88, 1'b0, 1'b0}, 5},
    '{2'b11, 8'hCC, 8'h0A, '{8'hCE, 1'b0, 1'b0}, 2},
    '{2'b00, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b1}, 0}
  };

  initial begin
    logic [1:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    int         r_stall;

    repeat (3) @(negedge wb_clk_i);
    check_reset_outputs("reset");
    check_val("reset_rsp_valid_hold", rsp_valid, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check_val("reset_cmd_ready", cmd_ready, 1);

    foreach (dir_tbl[i])
      do_op(dir_tbl[i].op, dir_tbl[i].a, dir_tbl[i].b, 1'b0, dir_tbl[i].a,
            dir_tbl[i].exp, dir_tbl[i].stall);

    // Reset asserted while the operation is in DRIVE: it must vanish.
    check_val("mid_reset_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h33; cmd_b = 8'h44;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    cmd_valid = 1'b0;
    wb_rst_i  = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    check_reset_outputs("mid_reset");
    wb_rst_i  = 1'b0;
    exp_count = '0;
    @(negedge wb_clk_i);
    check_val("post_reset_rsp_valid", rsp_valid, 0);
    check_val("post_reset_cmd_ready", cmd_ready, 1);
    $display("reset in DRIVE: operation discarded");

    do_op(2'b01, 8'h40, 8'h01, 1'b0, 8'h40, '{8'h3F, 1'b0, 1'b0}, 0);

`ifdef ALU_SEQ_CHAIN_EN
    do_op(2'b00, 8'h01, 8'h01, 1'b0, 8'h01, '{8'h02, 1'b0, 1'b0}, 0);
    do_op(2'b00, 8'hEE, 8'h03, 1'b1, 8'h02, '{8'h05, 1'b0, 1'b0}, 0);
`endif

    // Random traffic; enough operations to wrap the 4-bit op_count.
    for (int i = 0; i < 20; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_a     = 8'($urandom);
      r_b     = 8'($urandom);
      r_stall = int'($urandom_range(0, 4)) - 1;
      do_op(r_op, r_a, r_b, 1'b0, r_a, ref_result(r_op, r_a, r_b), r_stall);
    end

    check_val("scoreboard_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
